// File: rtl/mux_scan_ctrl_pkg.sv
// Shared definitions for the multiplexer scan controller: state encoding,
// channel/counter widths and a lowest-set-bit helper for channel search.
package mux_scan_ctrl_pkg;

  localparam int NCH   = 4;
  localparam int SEL_W = 2;
  localparam int CNT_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic             found;
    logic [SEL_W-1:0] idx;
  } chan_pick_t;

  // Lowest set bit of a channel vector; found=0 when the vector is empty.
  function automatic chan_pick_t lowest_set(input logic [NCH-1:0] vec);
    chan_pick_t r;
    r.found = 1'b0;
    r.idx   = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (vec[i]) begin
        r.found = 1'b1;
        r.idx   = i[SEL_W-1:0];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/mux_scan_ctrl_if.sv
// Scan request, mux select/data and result handshake between the
// controller (slave) and its environment (master).
interface mux_scan_ctrl_if;
  import mux_scan_ctrl_pkg::*;

  logic             start;
  logic [NCH-1:0]   en_mask;
  logic             cont;
  logic             y_in;
  logic [SEL_W-1:0] sel;
  logic             busy;
  logic [NCH-1:0]   out_data;
  logic             out_valid;
  logic             out_ready;

  modport master (
    output start, en_mask, cont, y_in, out_ready,
    input  sel, busy, out_data, out_valid
  );

  modport slave (
    input  start, en_mask, cont, y_in, out_ready,
    output sel, busy, out_data, out_valid
  );
endinterface

// File: rtl/mux_scan_ctrl_scan_dwell_cnt.sv
// Dwell down-counter: loads DWELL-1, counts down to zero and flags zero.
module scan_dwell_cnt
  import mux_scan_ctrl_pkg::*;
#(
  parameter int DWELL = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_load,
  input  logic i_dec,
  output logic o_zero
);

  // An 8-bit counter can only represent dwell lengths of 1..256.
  if (DWELL < 1 || DWELL > 256) begin : g_bad_dwell
    $fatal(1, "scan_dwell_cnt: DWELL must be in 1..256");
  end

  localparam int unsigned             LOAD_INT = DWELL - 1;
  localparam logic [CNT_W-1:0]        LOAD_VAL = LOAD_INT[CNT_W-1:0];

  logic [CNT_W-1:0] r_cnt;

  // Load takes priority; decrement saturates at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= LOAD_VAL;
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/mux_scan_ctrl.sv
// Scans the enabled channels of a downstream 4:1 mux in ascending order,
// holding each select for DWELL cycles before capturing its 1-bit output,
// then presents the assembled word under a valid/ready handshake.
module mux_scan_ctrl
  import mux_scan_ctrl_pkg::*;
#(
  parameter int DWELL = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  mux_scan_ctrl_if.slave        bus
);

  state_t           r_state;
  state_t           w_state_next;
  logic [NCH-1:0]   r_mask;
  logic [NCH-1:0]   r_data;
  logic [SEL_W-1:0] r_sel;

  logic             w_cnt_zero;
  logic             w_handshake;
  logic             w_accept;
  logic             w_capture;
  logic             w_load;
  logic             w_dec;
  logic [NCH-1:0]   w_above;
  chan_pick_t       w_first;
  chan_pick_t       w_next;

  // A scan is accepted from IDLE on start, or straight out of DONE on the
  // handshake edge when continuous mode is on (no idle cycle in between).
  assign w_handshake = (r_state == DONE) && bus.out_ready;
  assign w_accept    = ((r_state == IDLE) && bus.start) || (w_handshake && bus.cont);
  assign w_capture   = (r_state == SCAN) && w_cnt_zero;
  assign w_load      = w_accept || w_capture;
  assign w_dec       = (r_state == SCAN) && !w_cnt_zero;

  // Candidate channels strictly above the current select, so the search
  // never wraps back to a lower channel within one scan.
  for (genvar gi = 0; gi < NCH; gi++) begin : g_above
    assign w_above[gi] = r_mask[gi] && (SEL_W'(gi) > r_sel);
  end

  assign w_first = lowest_set(bus.en_mask);
  assign w_next  = lowest_set(w_above);

  scan_dwell_cnt #(
    .DWELL (DWELL)
  ) u_dwell (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_load (w_load),
    .i_dec  (w_dec),
    .o_zero (w_cnt_zero)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state decision.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: begin
        if (bus.start) begin
          w_state_next = w_first.found ? SCAN : DONE;
        end
      end
      SCAN: begin
        if (w_cnt_zero) begin
          w_state_next = w_next.found ? SCAN : DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          if (bus.cont) begin
            w_state_next = w_first.found ? SCAN : DONE;
          end else begin
            w_state_next = IDLE;
          end
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Mask, captured data and select; sel holds through DONE and returns
  // to 0 only when the handshake drops back to IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mask <= '0;
      r_data <= '0;
      r_sel  <= '0;
    end else if (w_accept) begin
      r_mask <= bus.en_mask;
      r_data <= '0;
      r_sel  <= w_first.found ? w_first.idx : '0;
    end else if (w_capture) begin
      r_data[r_sel] <= bus.y_in;
      r_mask[r_sel] <= 1'b0;
      if (w_next.found) begin
        r_sel <= w_next.idx;
      end
    end else if (w_handshake) begin
      r_sel <= '0;
    end
  end

  // Outputs decoded from state and datapath registers.
  always_comb begin
    bus.busy      = (r_state != IDLE);
    bus.out_valid = (r_state == DONE);
    bus.sel       = r_sel;
    bus.out_data  = r_data;
  end

endmodule
